maxnet_feeder: RTL and testbench
================================

Name: maxnet_feeder

Overview:
- Initiator side of the Maxnet start/done protocol.
- Accepts a serial stream of WIDTH-bit samples over a valid/ready input and packs four samples into X1..X4.
- Pulses mx_start, waits for Maxnet to complete, captures mx_result, and presents it on a valid/ready output.
- Sits between the sample source and the Maxnet top; includes a completion watchdog.

Parameters:
- WIDTH, 5, bit width of each sample and of the result.
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before the frame is abandoned (must be ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source has a sample on in_data.
- in_data  input  WIDTH  sample value.
- in_ready  output  1  feeder accepts a sample this cycle.
- X1  output  WIDTH  frame sample 0, to Maxnet.
- X2  output  WIDTH  frame sample 1.
- X3  output  WIDTH  frame sample 2.
- X4  output  WIDTH  frame sample 3.
- mx_start  output  1  one-cycle start pulse to Maxnet.
- mx_done  input  1  Maxnet done.
- mx_result  input  WIDTH  Maxnet result.
- out_valid  output  1  out_data holds a captured result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  captured result.
- timeout  output  1  one-cycle pulse when a frame is abandoned.

Behaviour:
- Reset values, applied asynchronously:
  - State LOAD, sample index 0, X1..X4 = 0.
  - mx_start = 0, out_valid = 0, out_data = 0, timeout = 0.
  - Watchdog counter = 0, done_d = 0.
  - in_ready = 1 once reset is released.
- FSM states: LOAD, START, WAIT, HOLD.
- LOAD:
  - in_ready = 1 (combinational on state).
  - A sample is accepted when in_valid & in_ready; it is registered into X[idx], idx = 0..3 maps to X1..X4, and idx increments.
  - On the accept with idx = 3: idx returns to 0 and the FSM goes to START.
  - No accept: hold state and index.
- START:
  - mx_start = 1 for exactly this cycle.
  - in_ready = 0.
  - Watchdog counter cleared.
  - Next state WAIT unconditionally.
- WAIT:
  - in_ready = 0.
  - Completion is the rising edge of mx_done: mx_done = 1 & done_d = 0, where done_d is mx_done registered every cycle.
  - A level-high done left over from a previous frame is ignored.
  - On completion: out_data <= mx_result, out_valid <= 1, next state HOLD.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT_CYCLES without completion: timeout = 1 for one cycle, frame discarded, out_data unchanged, next state LOAD.
  - If completion and counter-reaches-limit occur in the same cycle, completion wins and no timeout pulse is issued.
- HOLD:
  - out_valid = 1, out_data stable, in_ready = 0.
  - On out_ready = 1: out_valid <= 0, next state LOAD.
  - mx_done edges are ignored in HOLD.
- X1..X4 change only on LOAD accepts. They are stable from START through WAIT and HOLD.
- Latency:
  - 4th accept at cycle T gives mx_start high at T+1.
  - Rising mx_done at cycle D gives out_valid high at D+1.
  - Minimum frame throughput is 4 + 1 + (Maxnet time) + 1 + 1 cycles.
- Widths: no arithmetic on data; values are passed through unchanged. The watchdog counter is ceil(log2(TIMEOUT_CYCLES+1)) bits wide and never wraps.
- Reset asserted mid-frame (any state) discards partial samples and any held result, and returns to the reset values above.

Test Plan:
- Back-to-back samples 3, 17, 31, 9 with in_valid held high, then Maxnet done rises with result 31:
  - X1..X4 = 3/17/31/9.
  - Single-cycle mx_start the cycle after the 4th accept.
  - out_valid and out_data = 31 the cycle after the done edge.
  - out_ready high: out_valid drops and in_ready returns to 1.
- Samples with gaps in in_valid, and out_ready held low for 5 cycles:
  - Index advances only on accepts.
  - out_valid and out_data stay stable while out_ready is low.
  - in_ready stays 0 until the handshake completes.
- mx_done held high across two frames:
  - Second frame does not complete until done falls and rises again.
  - No spurious out_valid.
- TIMEOUT_CYCLES = 8, mx_done never rises:
  - timeout pulses exactly once, 8 cycles into WAIT.
  - out_valid never asserts; FSM is back in LOAD with in_ready = 1.
- Done rising edge on the same cycle the counter reaches the limit: result is captured and timeout stays 0.
- Reset asserted after 2 accepted samples and again during HOLD:
  - All outputs return to reset values.
  - The next four samples form a fresh frame starting at X1.

Source files
------------

// File: rtl/maxnet_feeder.sv
// Maxnet initiator: packs four serial samples into X1..X4, starts Maxnet,
// waits for the done edge under a watchdog and hands the result downstream.
module maxnet_feeder #(
    parameter int WIDTH          = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] X1,
    output logic [WIDTH-1:0] X2,
    output logic [WIDTH-1:0] X3,
    output logic [WIDTH-1:0] X4,
    output logic             mx_start,
    input  logic             mx_done,
    input  logic [WIDTH-1:0] mx_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        HOLD
    } state_e;

    state_e           state_q;
    logic [1:0]       idx_q;
    logic [WIDTH-1:0] x_q [4];
    logic             mx_start_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             timeout_q;
    logic [CW-1:0]    cnt_q;
    logic             done_prev_q;
    logic             done_rise;

    assign done_rise = mx_done & ~done_prev_q;
    assign in_ready  = (state_q == LOAD);

    assign X1        = x_q[0];
    assign X2        = x_q[1];
    assign X3        = x_q[2];
    assign X4        = x_q[3];
    assign mx_start  = mx_start_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign timeout   = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            idx_q       <= 2'd0;
            x_q[0]      <= '0;
            x_q[1]      <= '0;
            x_q[2]      <= '0;
            x_q[3]      <= '0;
            mx_start_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            done_prev_q <= 1'b0;
        end else begin
            done_prev_q <= mx_done;
            mx_start_q  <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        x_q[idx_q] <= in_data;
                        idx_q      <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q    <= START;
                            mx_start_q <= 1'b1;
                        end
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A done edge on the final watchdog cycle still wins.
                    if (done_rise) begin
                        out_data_q  <= mx_result;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            timeout_q <= 1'b1;
                            state_q   <= LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed bench for maxnet_feeder with a per-cycle reference model.
// Watchdog shortened to 8 cycles so timeout and race cases stay quick.
`timescale 1ns/1ps
module tb_maxnet_feeder;

    localparam int W  = 5;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [W-1:0] X1, X2, X3, X4;
    logic         mx_start;
    logic         mx_done;
    logic [W-1:0] mx_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         timeout;

    int n_tests = 0;
    int n_fail  = 0;

    maxnet_feeder #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .X1(X1), .X2(X2), .X3(X3), .X4(X4),
        .mx_start(mx_start), .mx_done(mx_done), .mx_result(mx_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: phase 0 collecting, 1 start, 2 awaiting done, 3 result held.
    int m_ph, m_n, m_wait, m_od;
    int m_x [4];
    bit m_start, m_to, m_ov, m_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_n = 0; m_wait = 0; m_od = 0;
            foreach (m_x[i]) m_x[i] = 0;
            m_start = 0; m_to = 0; m_ov = 0; m_prev = 0;
        end else begin
            m_start = 0;
            m_to    = 0;
            if (m_ph == 0) begin
                if (in_valid) begin
                    m_x[m_n] = int'(in_data);
                    m_n++;
                    if (m_n == 4) begin
                        m_n = 0; m_ph = 1; m_start = 1;
                    end
                end
            end else if (m_ph == 1) begin
                m_ph = 2; m_wait = 0;
            end else if (m_ph == 2) begin
                if (mx_done && !m_prev) begin
                    m_od = int'(mx_result); m_ov = 1; m_ph = 3;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_to = 1; m_ph = 0;
                    end
                end
            end else begin
                if (out_ready) begin
                    m_ov = 0; m_ph = 0;
                end
            end
            m_prev = mx_done;
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  in_ready,  (m_ph == 0) ? 1 : 0);
        chk("X1",        X1,        m_x[0]);
        chk("X2",        X2,        m_x[1]);
        chk("X3",        X3,        m_x[2]);
        chk("X4",        X4,        m_x[3]);
        chk("mx_start",  mx_start,  m_start);
        chk("out_valid", out_valid, m_ov);
        chk("out_data",  out_data,  m_od);
        chk("timeout",   timeout,   m_to);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        in_data  = W'(v);
        step();
        in_valid = 1'b0;
        in_data  = 5'd0;
    endtask

    task automatic frame(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
    endtask

    int to_at;
    int to_cnt;
    int ov_seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        mx_done = 1'b0; mx_result = '0; out_ready = 1'b0;
        step(2);
        rst = 1'b0;
        step();
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);

        // Back-to-back frame, done rises with result 31.
        frame(3, 17, 31, 9);
        chk("t1 mx_start", mx_start, 1);
        chk("t1 X1", X1, 3);
        chk("t1 X2", X2, 17);
        chk("t1 X3", X3, 31);
        chk("t1 X4", X4, 9);
        step();
        chk("t1 start pulse ends", mx_start, 0);
        step();
        mx_done = 1'b1; mx_result = 5'd31;
        step();
        chk("t1 out_valid", out_valid, 1);
        chk("t1 out_data", out_data, 31);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; mx_done = 1'b0;
        chk("t1 out_valid drop", out_valid, 0);
        chk("t1 in_ready back", in_ready, 1);

        // Gapped input, consumer stalls for 5 cycles.
        send(4); in_data = 5'd30; step(2);
        send(5); step();
        in_data = 5'd29; step();
        send(6); step(3); send(7);
        chk("t2 X1", X1, 4);
        chk("t2 X4", X4, 7);
        step(3);
        mx_done = 1'b1; mx_result = 5'd12;
        step();
        mx_done = 1'b0;
        step(5);
        chk("t2 held data", out_data, 12);
        chk("t2 held in_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Done level held high across two frames.
        frame(1, 2, 3, 4);
        step(2);
        mx_done = 1'b1; mx_result = 5'd7;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        frame(10, 11, 12, 13);
        step(4);
        chk("t3 no stale done", out_valid, 0);
        mx_done = 1'b0;
        step();
        mx_done = 1'b1; mx_result = 5'd14;
        step();
        chk("t3 out_valid", out_valid, 1);
        chk("t3 out_data", out_data, 14);
        mx_done = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Watchdog expiry: done never rises.
        frame(8, 9, 10, 11);
        to_at = 0; to_cnt = 0; ov_seen = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (timeout) begin
                to_cnt++;
                to_at = i;
            end
            if (out_valid) ov_seen = 1;
        end
        chk("t4 timeout count", to_cnt, 1);
        chk("t4 timeout cycle", to_at, TO + 1);
        chk("t4 no out_valid", ov_seen, 0);
        chk("t4 data kept", out_data, 14);
        chk("t4 in_ready", in_ready, 1);

        // Done edge on the last watchdog cycle.
        frame(20, 21, 22, 23);
        step(TO);
        mx_done = 1'b1; mx_result = 5'd22;
        step();
        chk("t5 out_valid", out_valid, 1);
        chk("t5 out_data", out_data, 22);
        chk("t5 no timeout", timeout, 0);
        mx_done = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        chk("t5 no late timeout", timeout, 0);

        // Reset mid-load, then fresh frame, then reset while holding.
        send(25); send(26);
        rst = 1'b1;
        step();
        chk("t6 X1 cleared", X1, 0);
        chk("t6 X2 cleared", X2, 0);
        rst = 1'b0;
        step();
        frame(5, 6, 7, 8);
        chk("t6 fresh X1", X1, 5);
        chk("t6 fresh X4", X4, 8);
        step(2);
        mx_done = 1'b1; mx_result = 5'd19;
        step();
        chk("t6 out_data", out_data, 19);
        rst = 1'b1;
        step();
        chk("t6 rst out_valid", out_valid, 0);
        chk("t6 rst out_data", out_data, 0);
        chk("t6 rst in_ready", in_ready, 1);
        rst = 1'b0; mx_done = 1'b0;
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
